// File: rtl/pdh_frame_streamer.sv
// Captures one frame of pdh_core DMA samples (optionally decimated), buffers them in a
// small show-ahead FIFO and emits the frame as a single AXI4-Stream packet.
module pdh_frame_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16,
    parameter int DECIM_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dma_enable_i,
    input  logic [DATA_WIDTH-1:0]          dma_data_i,
    input  logic [DECIM_W-1:0]             decim_i,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           dma_finished_o,
    output logic                           overflow_o,
    output logic [$clog2(FRAME_LEN+1)-1:0] sample_cnt_o
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic               enable_q_reg;
    logic [DECIM_W-1:0] decim_reg, decim_next;
    logic [DECIM_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [CNT_W-1:0]   sample_cnt_reg, sample_cnt_next;
    logic               overflow_reg, overflow_next;

    logic [ENT_W-1:0]   entry_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]   occ_reg;

    logic start;
    logic tick;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic sample_last;

    assign start       = dma_enable_i & ~enable_q_reg;
    assign fifo_full   = (occ_reg == OCC_W'(FIFO_DEPTH));
    assign fifo_empty  = (occ_reg == '0);
    // A tick left unserved by a full FIFO keeps the counter at zero, so it stays pending.
    assign tick        = (state_reg == CAPTURE) && (tick_cnt_reg == '0);
    assign push        = tick & ~fifo_full;
    assign pop         = ~fifo_empty & m_axis_tready;
    assign sample_last = (sample_cnt_reg == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            enable_q_reg   <= 1'b0;
            decim_reg      <= '0;
            tick_cnt_reg   <= '0;
            sample_cnt_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            enable_q_reg   <= dma_enable_i;
            decim_reg      <= decim_next;
            tick_cnt_reg   <= tick_cnt_next;
            sample_cnt_reg <= sample_cnt_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        decim_next      = decim_reg;
        tick_cnt_next   = tick_cnt_reg;
        sample_cnt_next = sample_cnt_reg;
        overflow_next   = overflow_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (push) begin
                    tick_cnt_next   = decim_reg;
                    sample_cnt_next = sample_cnt_reg + CNT_W'(1);
                    if (sample_last) state_next = DRAIN;
                end else if (tick) begin
                    overflow_next = 1'b1;
                end else begin
                    tick_cnt_next = tick_cnt_reg - DECIM_W'(1);
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) state_next = DONE;
            end
            DONE: begin
                if (start)              state_next = CAPTURE;
                else if (!dma_enable_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Frame arming: zero tick count makes the first CAPTURE cycle sample immediately.
        if (start && (state_reg == IDLE || state_reg == DONE)) begin
            decim_next      = decim_i;
            tick_cnt_next   = '0;
            sample_cnt_next = '0;
            overflow_next   = 1'b0;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [ENT_W-1:0] entry_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= {sample_last, dma_data_i};
            end
        end

        assign entry_q[gi] = entry_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign m_axis_tvalid  = ~fifo_empty;
    assign m_axis_tdata   = entry_q[rd_ptr_reg][DATA_WIDTH-1:0];
    assign m_axis_tlast   = entry_q[rd_ptr_reg][DATA_WIDTH];
    assign dma_finished_o = (state_reg == DONE);
    assign overflow_o     = overflow_reg;
    assign sample_cnt_o   = sample_cnt_reg;

endmodule
